// File: rtl/sdram_arbiter.sv
// Two-master Avalon-MM arbiter for one SDRAM port (master 0 = vjtag, master 1 = cpu).
// An ID FIFO records the owner of each outstanding read so that returned data goes back in issue order.
module sdram_arbiter #(
   parameter int MAX_PENDING = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  m0_address,
   input  logic                         m0_read,
   input  logic                         m0_write,
   input  logic [31:0]                  m0_writedata,
   input  logic [3:0]                   m0_byteenable,
   output logic [31:0]                  m0_readdata,
   output logic                         m0_waitrequest,
   output logic                         m0_readdatavalid,
   input  logic [31:0]                  m1_address,
   input  logic                         m1_read,
   input  logic                         m1_write,
   input  logic [31:0]                  m1_writedata,
   input  logic [3:0]                   m1_byteenable,
   output logic [31:0]                  m1_readdata,
   output logic                         m1_waitrequest,
   output logic                         m1_readdatavalid,
   output logic [31:0]                  sdram_address,
   output logic                         sdram_read,
   output logic                         sdram_write,
   output logic [31:0]                  sdram_writedata,
   output logic [3:0]                   sdram_byteenable,
   input  logic [31:0]                  sdram_readdata,
   input  logic                         sdram_waitrequest,
   input  logic                         sdram_readdatavalid,
   output logic [$clog2(MAX_PENDING):0] pending,
   output logic                         err
);
   localparam int PW = $clog2(MAX_PENDING);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(MAX_PENDING);

   logic          lock_q, lock_d;
   logic          owner_q, owner_d;
   logic          prio_q, prio_d;
   logic          err_q, err_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          fifo_q [MAX_PENDING];
   logic          fifo_d [MAX_PENDING];

   logic req0, req1, elig0, elig1, full;
   logic sel, sel_vld, sel_read, issue, accept, push, pop, head;

   // Selection: a locked owner keeps the port until its stalled request is accepted.
   always_comb begin
      full    = (count_q == FULL_CNT);
      req0    = m0_read | m0_write;
      req1    = m1_read | m1_write;
      elig0   = m0_write | (m0_read & ~full);
      elig1   = m1_write | (m1_read & ~full);
      sel     = 1'b0;
      sel_vld = 1'b0;
      if (lock_q) begin
         sel_vld = 1'b1;
         sel     = owner_q;
      end else if (elig0 && elig1) begin
         sel_vld = 1'b1;
         sel     = prio_q;
      end else if (elig0) begin
         sel_vld = 1'b1;
         sel     = 1'b0;
      end else if (elig1) begin
         sel_vld = 1'b1;
         sel     = 1'b1;
      end
      issue    = rst & sel_vld & (sel ? req1 : req0);
      sel_read = sel ? m1_read : m0_read;
      accept   = issue & ~sdram_waitrequest;
      push     = accept & sel_read & (~full | pop);
      pop      = sdram_readdatavalid & (count_q != '0);
      head     = fifo_q[rd_ptr_q];
   end

   always_comb begin
      sdram_address    = sel ? m1_address    : m0_address;
      sdram_writedata  = sel ? m1_writedata  : m0_writedata;
      sdram_byteenable = sel ? m1_byteenable : m0_byteenable;
      sdram_read       = issue & (sel ? m1_read  : m0_read);
      sdram_write      = issue & (sel ? m1_write : m0_write);
      m0_waitrequest   = !rst ? 1'b1 : ((issue && !sel) ? sdram_waitrequest : req0);
      m1_waitrequest   = !rst ? 1'b1 : ((issue &&  sel) ? sdram_waitrequest : req1);
      m0_readdatavalid = rst & pop & ~head;
      m1_readdatavalid = rst & pop &  head;
      m0_readdata      = sdram_readdata;
      m1_readdata      = sdram_readdata;
      pending          = count_q;
      err              = err_q;
   end

   always_comb begin
      lock_d   = lock_q;
      owner_d  = owner_q;
      prio_d   = prio_q;
      err_d    = err_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fifo_d   = fifo_q;
      if (issue) begin
         if (sdram_waitrequest) begin
            lock_d  = 1'b1;
            owner_d = sel;
         end else begin
            lock_d = 1'b0;
            prio_d = ~sel;
         end
      end else if (lock_q) begin
         // Owner dropped its request while stalled: release the port and flag it.
         lock_d = 1'b0;
         err_d  = 1'b1;
      end
      if (sdram_readdatavalid && count_q == '0) begin
         err_d = 1'b1;
      end
      if (push) begin
         fifo_d[wr_ptr_q] = sel;
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lock_q   <= 1'b0;
         owner_q  <= 1'b0;
         prio_q   <= 1'b0;
         err_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         lock_q   <= lock_d;
         owner_q  <= owner_d;
         prio_q   <= prio_d;
         err_q    <= err_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // ID storage needs no reset: entries are only read below the registered count.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: directed scenarios followed by randomized two-master traffic.
module tb_sdram_arbiter;
   localparam int MP = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m0_address, m0_writedata, m0_readdata;
   logic        m0_read, m0_write, m0_waitrequest, m0_readdatavalid;
   logic [3:0]  m0_byteenable;
   logic [31:0] m1_address, m1_writedata, m1_readdata;
   logic        m1_read, m1_write, m1_waitrequest, m1_readdatavalid;
   logic [3:0]  m1_byteenable;
   logic [31:0] sdram_address, sdram_writedata, sdram_readdata;
   logic        sdram_read, sdram_write, sdram_waitrequest, sdram_readdatavalid;
   logic [3:0]  sdram_byteenable;
   logic [$clog2(MP):0] pending;
   logic        err;

   sdram_arbiter #(.MAX_PENDING(MP)) dut (
      .clk(clk), .rst(rst),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
      .sdram_address(sdram_address), .sdram_read(sdram_read), .sdram_write(sdram_write),
      .sdram_writedata(sdram_writedata), .sdram_byteenable(sdram_byteenable),
      .sdram_readdata(sdram_readdata), .sdram_waitrequest(sdram_waitrequest),
      .sdram_readdatavalid(sdram_readdatavalid), .pending(pending), .err(err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];
   logic [31:0] ret_q[$];
   bit          act[2];
   bit          rd_r[2];
   logic [31:0] addr_r[2];
   logic [31:0] data_r[2];
   logic [3:0]  be_r[2];
   bit          acc[2];
   bit          auto_mode = 1'b0;
   bit          stop_new  = 1'b0;
   int          model_cnt = 0;
   bit          model_err = 1'b0;
   logic        s_rd, s_wr, s_w0, s_w1, s_v0, s_v1;
   logic [31:0] s_addr;

   task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
      end
   endtask

   function automatic logic [31:0] rd_data(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   task automatic drive_masters();
      m0_read       = act[0] & rd_r[0];
      m0_write      = act[0] & ~rd_r[0];
      m0_address    = addr_r[0];
      m0_writedata  = data_r[0];
      m0_byteenable = be_r[0];
      m1_read       = act[1] & rd_r[1];
      m1_write      = act[1] & ~rd_r[1];
      m1_address    = addr_r[1];
      m1_writedata  = data_r[1];
      m1_byteenable = be_r[1];
   endtask

   task automatic start(input int x, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be);
      act[x]    = 1'b1;
      rd_r[x]   = rd;
      addr_r[x] = a;
      data_r[x] = d;
      be_r[x]   = be;
      drive_masters();
   endtask

   task automatic ret_pulse();
      sdram_readdatavalid = 1'b1;
      sdram_readdata      = (ret_q.size() > 0) ? ret_q[0] : 32'hDEAD_BEEF;
   endtask

   // Sampled on the falling edge: handshakes, routing and the reference counters.
   task automatic observe();
      bit acc_rd;
      check("pending", 32'(pending), 32'(model_cnt));
      check("err", 32'(err), 32'(model_err));
      acc[0] = act[0] && !m0_waitrequest;
      acc[1] = act[1] && !m1_waitrequest;
      s_rd = sdram_read;   s_wr = sdram_write;  s_addr = sdram_address;
      s_w0 = m0_waitrequest; s_w1 = m1_waitrequest;
      s_v0 = m0_readdatavalid; s_v1 = m1_readdatavalid;
      check("single grant", 32'(acc[0] & acc[1]), 0);
      if (!act[0] && !act[1]) begin
         check("idle read", 32'(sdram_read), 0);
         check("idle write", 32'(sdram_write), 0);
      end
      acc_rd = 1'b0;
      for (int x = 0; x < 2; x++) begin
         if (acc[x]) begin
            check("acc addr", sdram_address, addr_r[x]);
            check("acc read", 32'(sdram_read), 32'(rd_r[x]));
            check("acc write", 32'(sdram_write), 32'(!rd_r[x]));
            if (rd_r[x]) begin
               acc_rd = 1'b1;
               if (x == 0) exp_q0.push_back(rd_data(addr_r[x]));
               else        exp_q1.push_back(rd_data(addr_r[x]));
            end else begin
               check("acc wdata", sdram_writedata, data_r[x]);
               check("acc be", 32'(sdram_byteenable), 32'(be_r[x]));
            end
         end
      end
      if (model_cnt == MP) check("full blocks read", 32'(acc_rd), 0);
      if (sdram_readdatavalid) begin
         if (ret_q.size() > 0) void'(ret_q.pop_front());
         if (model_cnt == 0) model_err = 1'b1;
         else                model_cnt--;
      end
      if (sdram_read && !sdram_waitrequest) ret_q.push_back(rd_data(sdram_address));
      if (acc_rd) model_cnt++;
   endtask

   task automatic step();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
      for (int x = 0; x < 2; x++) if (acc[x]) act[x] = 1'b0;
      sdram_readdatavalid = 1'b0;
      if (auto_mode) begin
         sdram_waitrequest = ($urandom_range(0, 3) == 0);
         if (ret_q.size() > 0 && $urandom_range(0, 2) == 0) ret_pulse();
         for (int x = 0; x < 2; x++) begin
            if (!act[x] && !stop_new && $urandom_range(0, 2) == 0)
               start(x, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
         end
      end
      drive_masters();
   endtask

   // Return-path scoreboard: each master's data must arrive in its own issue order.
   always @(negedge clk) begin
      if (m0_readdatavalid) begin
         if (exp_q0.size() == 0) check("m0 rdv spurious", 32'(m0_readdatavalid), 0);
         else                    check("m0 readdata", m0_readdata, exp_q0.pop_front());
      end
      if (m1_readdatavalid) begin
         if (exp_q1.size() == 0) check("m1 rdv spurious", 32'(m1_readdatavalid), 0);
         else                    check("m1 readdata", m1_readdata, exp_q1.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      sdram_waitrequest = 1'b0; sdram_readdatavalid = 1'b0; sdram_readdata = '0;
      for (int x = 0; x < 2; x++) begin
         act[x] = 1'b0; rd_r[x] = 1'b0; addr_r[x] = '0; data_r[x] = '0; be_r[x] = '0; acc[x] = 1'b0;
      end
      drive_masters();
      #2 rst = 1'b0;
      start(0, 1'b1, 32'h0000_0010, 32'h0, 4'hF);
      start(1, 1'b0, 32'h0000_0020, 32'h1, 4'hF);
      #10;
      check("rst sdram_read", 32'(sdram_read), 0);
      check("rst sdram_write", 32'(sdram_write), 0);
      check("rst m0 wait", 32'(m0_waitrequest), 1);
      check("rst m1 wait", 32'(m1_waitrequest), 1);
      check("rst pending", 32'(pending), 0);
      check("rst err", 32'(err), 0);
      act[0] = 1'b0; act[1] = 1'b0; drive_masters();
      @(posedge clk); #1 rst = 1'b1;

      // Simultaneous reads after reset: m0 first, then m1, data returned in that order.
      start(0, 1'b1, 32'h0000_1000, 32'h0, 4'hF);
      start(1, 1'b1, 32'h0000_2000, 32'h0, 4'hF);
      step();
      check("r20 c1 m0 grant", 32'(acc[0]), 1);
      check("r20 c1 m1 stalled", 32'(s_w1), 1);
      step();
      check("r20 c2 m1 grant", 32'(acc[1]), 1);
      ret_pulse(); step();
      check("r20 ret1 to m0", 32'(s_v0), 1);
      ret_pulse(); step();
      check("r20 ret2 to m1", 32'(s_v1), 1);

      // Stalled m1 write keeps the port for four cycles.
      sdram_waitrequest = 1'b1;
      start(1, 1'b0, 32'h0000_3000, 32'hCAFE_0001, 4'h3);
      step();
      check("r21 c1 addr", s_addr, 32'h0000_3000);
      start(0, 1'b0, 32'h0000_4000, 32'hBEEF_0002, 4'hC);
      for (int i = 0; i < 2; i++) begin
         step();
         check("r21 locked addr", s_addr, 32'h0000_3000);
         check("r21 m0 wait", 32'(s_w0), 1);
      end
      sdram_waitrequest = 1'b0;
      step();
      check("r21 c4 m1 accept", 32'(acc[1]), 1);
      check("r21 c4 m0 wait", 32'(s_w0), 1);
      step();
      check("r21 c5 m0 accept", 32'(acc[0]), 1);
      check("r21 c5 addr", s_addr, 32'h0000_4000);

      // Read FIFO full: fifth read waits, writes still pass, return frees a slot a cycle later.
      for (int i = 0; i < 4; i++) begin
         start(0, 1'b1, 32'h0000_5000 + 32'(i * 4), 32'h0, 4'hF);
         step();
         check("r22 read issued", 32'(acc[0]), 1);
      end
      start(0, 1'b1, 32'h0000_5100, 32'h0, 4'hF);
      step();
      check("r22 held read", 32'(s_rd), 0);
      check("r22 held wait", 32'(s_w0), 1);
      check("r22 pending full", 32'(pending), 4);
      start(1, 1'b0, 32'h0000_6000, 32'h1234_5678, 4'hF);
      step();
      check("r22 write passes", 32'(acc[1]), 1);
      check("r22 m0 still held", 32'(acc[0]), 0);
      ret_pulse(); step();
      check("r22 no same-cycle unblock", 32'(acc[0]), 0);
      step();
      check("r22 read after return", 32'(acc[0]), 1);
      for (int i = 0; i < 4; i++) begin ret_pulse(); step(); end

      // Push and pop in one cycle at two pending.
      start(0, 1'b1, 32'h0000_7000, 32'h0, 4'hF); step();
      start(1, 1'b1, 32'h0000_7100, 32'h0, 4'hF); step();
      start(0, 1'b1, 32'h0000_7200, 32'h0, 4'hF);
      ret_pulse(); step();
      check("r23 push accepted", 32'(acc[0]), 1);
      check("r23 pending kept", 32'(pending), 2);
      for (int i = 0; i < 2; i++) begin ret_pulse(); step(); end

      // Locked owner abandons its request.
      sdram_waitrequest = 1'b1;
      start(1, 1'b0, 32'h0000_8000, 32'h0000_00AA, 4'hF);
      step();
      act[1] = 1'b0; drive_masters();
      sdram_waitrequest = 1'b0;
      step();
      model_err = 1'b1;
      check("r15 err set", 32'(err), 1);

      // Reset mid-cycle with three reads outstanding.
      for (int i = 0; i < 3; i++) begin
         start(0, 1'b1, 32'h0000_9000 + 32'(i * 4), 32'h0, 4'hF);
         step();
      end
      start(0, 1'b1, 32'h0000_9100, 32'h0, 4'hF);
      start(1, 1'b0, 32'h0000_A000, 32'h0000_0055, 4'hF);
      #2 rst = 1'b0;
      sdram_readdatavalid = 1'b1;
      sdram_readdata = ret_q[0];
      #1;
      check("r25 pending", 32'(pending), 0);
      check("r25 err", 32'(err), 0);
      check("r25 sdram_read", 32'(sdram_read), 0);
      check("r25 sdram_write", 32'(sdram_write), 0);
      check("r25 m0 wait", 32'(m0_waitrequest), 1);
      check("r25 m1 wait", 32'(m1_waitrequest), 1);
      check("r25 m0 rdv", 32'(m0_readdatavalid), 0);
      check("r25 m1 rdv", 32'(m1_readdatavalid), 0);
      model_cnt = 0; model_err = 1'b0;
      exp_q0.delete(); exp_q1.delete();
      act[0] = 1'b0; act[1] = 1'b0; drive_masters();
      sdram_readdatavalid = 1'b0;
      @(posedge clk); #1;
      check("r25 pending held", 32'(pending), 0);
      rst = 1'b1;

      // Stale return after reset is dropped and flags err.
      ret_pulse(); step();
      check("r19 stale m0", 32'(s_v0), 0);
      check("r19 stale m1", 32'(s_v1), 0);
      check("r24 err set", 32'(err), 1);
      ret_q.delete();
      start(0, 1'b1, 32'h0000_B000, 32'h0, 4'hF);
      start(1, 1'b0, 32'h0000_C000, 32'h0000_0077, 4'h5);
      step();
      check("r25 prio m0 first", 32'(acc[0]), 1);
      check("r25 prio m1 waits", 32'(acc[1]), 0);
      step();
      check("r25 m1 next", 32'(acc[1]), 1);
      ret_pulse(); step();

      // Randomized traffic, then drain.
      auto_mode = 1'b1;
      repeat (1500) step();
      stop_new = 1'b1;
      for (int i = 0; i < 500 && (act[0] || act[1] || ret_q.size() > 0 || sdram_readdatavalid); i++) step();
      auto_mode = 1'b0;
      sdram_waitrequest = 1'b0;
      step();
      check("drain ret_q", 32'(ret_q.size()), 0);
      check("drain m0 busy", 32'(act[0]), 0);
      check("drain m1 busy", 32'(act[1]), 0);
      check("drain exp m0", 32'(exp_q0.size()), 0);
      check("drain exp m1", 32'(exp_q1.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
